// File: rtl/axi_rdata_xbar.sv
// AXI R-channel crossbar: routes read beats from NUM_S slaves to NUM_M masters by RID master index.
// Latency: 0 cycles (combinational forwarding); +1 cycle with AXI_RDX_PIPE_EN (2-entry skid slice per master).
// Backpressure: m_rready gates s_rready of the granted slave; with AXI_RDX_PIPE_EN s_rready follows slice occupancy only.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_rid/s_rdata/s_rresp/s_rlast/s_rvalid/s_rready   NUM_S slave R channels, slave k in slice k
//   m_rid/m_rdata/m_rresp/m_rlast/m_rvalid/m_rready   NUM_M master R channels, master m in slice m
//   drop_err              pulses when a beat with an out-of-range master index is discarded
//
// Optional build macro: AXI_RDX_PIPE_EN (registered master outputs through a 2-entry skid slice).
//
// Each master has its own round-robin arbiter. Once a beat from the granted slave is presented
// and the burst is not finished, the arbiter locks onto that slave until the RLAST handshake, so
// bursts are never interleaved and a presented beat is never withdrawn by re-arbitration.

module axi_rdata_xbar #(
    parameter int NUM_S  = 3,
    parameter int NUM_M  = 2,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32,
    parameter int MIDX_W = 4,
    localparam int IDS_W = MIDX_W + ID_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_S*IDS_W-1:0]   s_rid,
    input  logic [NUM_S*DATA_W-1:0]  s_rdata,
    input  logic [NUM_S*2-1:0]       s_rresp,
    input  logic [NUM_S-1:0]         s_rlast,
    input  logic [NUM_S-1:0]         s_rvalid,
    output logic [NUM_S-1:0]         s_rready,
    output logic [NUM_M*ID_W-1:0]    m_rid,
    output logic [NUM_M*DATA_W-1:0]  m_rdata,
    output logic [NUM_M*2-1:0]       m_rresp,
    output logic [NUM_M-1:0]         m_rlast,
    output logic [NUM_M-1:0]         m_rvalid,
    input  logic [NUM_M-1:0]         m_rready,
    output logic                     drop_err
);

    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    // (base + off) mod NUM_S for off in 0..NUM_S-1
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_S) s = s - NUM_S;
        return SW'(s);
    endfunction

    logic [MIDX_W-1:0] tgt      [NUM_S];
    logic [SW-1:0]     rr_ptr   [NUM_M];
    logic [SW-1:0]     lock_slv [NUM_M];
    logic [NUM_M-1:0]  lock;
    logic [SW-1:0]     gnt      [NUM_M];
    logic [NUM_M-1:0]  gnt_vld;
    logic [NUM_M-1:0]  beat_vld;   // granted slave is presenting a beat
    logic [NUM_M-1:0]  beat_acc;   // that beat is taken by the output stage this cycle
    logic [NUM_M-1:0]  out_rdy;    // output stage can take a beat
    beat_t             in_beat  [NUM_M];

    // ------------------------------------------------------------------
    // Target decode: master index lives above the master-side ID bits
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < NUM_S; k++) begin
            tgt[k] = s_rid[k*IDS_W + ID_W +: MIDX_W];
        end
    end

    // ------------------------------------------------------------------
    // Per-master arbitration
    // ------------------------------------------------------------------
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            gnt[m]     = '0;
            gnt_vld[m] = 1'b0;
            if (lock[m]) begin
                gnt[m]     = lock_slv[m];
                gnt_vld[m] = 1'b1;
            end else begin
                // Walk offsets high to low so the lowest offset from rr_ptr wins.
                for (int off = NUM_S - 1; off >= 0; off--) begin
                    if (s_rvalid[wrap_inc(rr_ptr[m], off)] &&
                        tgt[wrap_inc(rr_ptr[m], off)] == MIDX_W'(m)) begin
                        gnt[m]     = wrap_inc(rr_ptr[m], off);
                        gnt_vld[m] = 1'b1;
                    end
                end
            end
        end
    end

    // Mux the granted slave's beat for each master
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            beat_vld[m] = gnt_vld[m] & s_rvalid[gnt[m]];
            beat_acc[m] = beat_vld[m] & out_rdy[m];
            in_beat[m]  = '0;
            if (beat_vld[m]) begin
                in_beat[m].id   = s_rid[int'(gnt[m])*IDS_W +: ID_W];
                in_beat[m].data = s_rdata[int'(gnt[m])*DATA_W +: DATA_W];
                in_beat[m].resp = s_rresp[int'(gnt[m])*2 +: 2];
                in_beat[m].last = s_rlast[gnt[m]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Slave readies and drop detection
    // ------------------------------------------------------------------
    always_comb begin
        s_rready = '0;
        drop_err = 1'b0;
        // Beats addressed to a non-existent master are sunk so the slave cannot stall.
        for (int k = 0; k < NUM_S; k++) begin
            if (s_rvalid[k] && int'(tgt[k]) >= NUM_M) begin
                s_rready[k] = 1'b1;
                drop_err    = 1'b1;
            end
        end
        // Targets are unique per beat, so no slave is granted by two masters.
        for (int m = 0; m < NUM_M; m++) begin
            if (beat_acc[m]) begin
                s_rready[gnt[m]] = 1'b1;
            end
        end
        if (rst) begin
            s_rready = '0;
            drop_err = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Lock and round-robin pointer state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= '0;
            for (int m = 0; m < NUM_M; m++) begin
                rr_ptr[m]   <= '0;
                lock_slv[m] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (beat_acc[m] && in_beat[m].last) begin
                    lock[m]   <= 1'b0;
                    rr_ptr[m] <= wrap_inc(gnt[m], 1);
                end else if (beat_vld[m]) begin
                    // Beat stalled or mid-burst: hold this slave until its RLAST handshake.
                    lock[m]     <= 1'b1;
                    lock_slv[m] <= gnt[m];
                end
            end
        end
    end

`ifdef AXI_RDX_PIPE_EN
    // ------------------------------------------------------------------
    // 2-entry skid slice per master; ready depends only on occupancy
    // ------------------------------------------------------------------
    beat_t            slc_mem [NUM_M][2];
    logic [NUM_M-1:0] slc_wp;
    logic [NUM_M-1:0] slc_rp;
    logic [1:0]       slc_cnt [NUM_M];
    logic [NUM_M-1:0] slc_pop;

    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            out_rdy[m] = (slc_cnt[m] != 2'd2);
            slc_pop[m] = (slc_cnt[m] != 2'd0) & m_rready[m];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slc_wp <= '0;
            slc_rp <= '0;
            for (int m = 0; m < NUM_M; m++) begin
                slc_cnt[m]    <= 2'd0;
                slc_mem[m][0] <= '0;
                slc_mem[m][1] <= '0;
            end
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                if (beat_acc[m]) begin
                    slc_mem[m][slc_wp[m]] <= in_beat[m];
                    slc_wp[m]             <= ~slc_wp[m];
                end
                if (slc_pop[m]) begin
                    slc_rp[m] <= ~slc_rp[m];
                end
                case ({beat_acc[m], slc_pop[m]})
                    2'b10:   slc_cnt[m] <= slc_cnt[m] + 2'd1;
                    2'b01:   slc_cnt[m] <= slc_cnt[m] - 2'd1;
                    default: slc_cnt[m] <= slc_cnt[m];
                endcase
            end
        end
    end

    always_comb begin
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = '0;
        m_rlast  = '0;
        m_rvalid = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (slc_cnt[m] != 2'd0) begin
                m_rvalid[m]                  = 1'b1;
                m_rid[m*ID_W +: ID_W]        = slc_mem[m][slc_rp[m]].id;
                m_rdata[m*DATA_W +: DATA_W]  = slc_mem[m][slc_rp[m]].data;
                m_rresp[m*2 +: 2]            = slc_mem[m][slc_rp[m]].resp;
                m_rlast[m]                   = slc_mem[m][slc_rp[m]].last;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // Combinational forwarding
    // ------------------------------------------------------------------
    always_comb begin
        out_rdy = m_rready;
    end

    always_comb begin
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = '0;
        m_rlast  = '0;
        m_rvalid = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (!rst && beat_vld[m]) begin
                m_rvalid[m]                  = 1'b1;
                m_rid[m*ID_W +: ID_W]        = in_beat[m].id;
                m_rdata[m*DATA_W +: DATA_W]  = in_beat[m].data;
                m_rresp[m*2 +: 2]            = in_beat[m].resp;
                m_rlast[m]                   = in_beat[m].last;
            end
        end
    end
`endif

endmodule

// File: doc/axi_rdata_xbar.md
Name: axi_rdata_xbar

Overview:
- Parametrised AXI read-data (R channel) crossbar returning read beats from NUM_S slaves to NUM_M masters.
- Each beat is routed by the master-index field in the upper bits of the slave-side RID.
- One independent round-robin arbiter per master, each with burst lock held until RLAST, so bursts to different masters proceed concurrently.
- Sits in the AXI interconnect beside the AR/AW/W/B channel blocks.

Parameters:
- NUM_S, 3, number of slave ports (2..8)
- NUM_M, 2, number of master ports (2..4)
- ID_W, 4, master-side ID width
- DATA_W, 32, data width
- MIDX_W, 4, master-index field width; slave-side ID width IDS_W = MIDX_W+ID_W

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_rid  in  NUM_S*IDS_W  slave RIDs, slave k at [k*IDS_W +: IDS_W]
- s_rdata  in  NUM_S*DATA_W  slave read data
- s_rresp  in  NUM_S*2  slave responses
- s_rlast  in  NUM_S  slave last-beat flags
- s_rvalid  in  NUM_S  slave valids
- s_rready  out  NUM_S  slave readies
- m_rid  out  NUM_M*ID_W  RID to masters (s_rid low ID_W bits)
- m_rdata  out  NUM_M*DATA_W  data to masters
- m_rresp  out  NUM_M*2  responses to masters
- m_rlast  out  NUM_M  last flags
- m_rvalid  out  NUM_M  valids
- m_rready  in  NUM_M  master readies
- drop_err  out  1  one-cycle pulse when a beat with an out-of-range master index is discarded

Behaviour:
- Reset (rst=1, asynchronous): all m_* and s_rready outputs 0, drop_err 0, every rr_ptr[m]=0, every lock[m]=0, grant[m] invalid.
- Target of slave k = s_rid[k] upper MIDX_W bits.
- Request req[m][k] = s_rvalid[k] & target==m.
- Per-master arbiter, unlocked: grant = first k with req[m][k] searching k=rr_ptr[m], rr_ptr[m]+1, ... mod NUM_S. Combinational, zero-cycle valid-to-valid.
- Locked: grant[m] holds the registered slave regardless of other requests.
- lock[m] set at a clock edge when the granted slave is valid and either not accepted (m_rready=0) or accepted with rlast=0. Valid must stay stable, and a burst is never interleaved.
- lock[m] cleared on the handshake of a beat with rlast=1. On that same edge rr_ptr[m] = granted k + 1 mod NUM_S.
- Single-beat bursts accepted immediately never set lock. rr_ptr still advances.
- Forwarding: m_rvalid[m] = s_rvalid[g]; m_rdata, m_rresp, m_rlast, m_rid taken from slave g.
- s_rready[g] = m_rready[m] & s_rvalid[g]. No grant means m_rvalid[m]=0 and m_* data fields 0.
- A slave is never granted by two masters: target is unique per beat.
- Out-of-range target (>=NUM_M): s_rready[k]=1 for that beat, beat discarded, drop_err=1 that cycle. Multiple simultaneous drops produce one pulse.
- Throughput: one beat per master per cycle; NUM_M concurrent bursts allowed.
- Reset mid-burst: locks and pointers cleared immediately; in-flight beats are lost by design (the whole fabric resets together).

Optional Feature:
- Macro: AXI_RDX_PIPE_EN.
- Defined: each master output gets a 2-entry skid register slice. m_* outputs are registered, latency +1 cycle, full throughput. s_rready depends only on slice occupancy (not m_rready combinationally). Lock/rr_ptr update on the beat entering the slice. Slice entries cleared by rst.
- Undefined: purely combinational forwarding as above.

Test Plan:
- Single beat: S1 rid=0x13 (m1, id 3), data 0xA5A5A5A5, rlast=1, m_rready[1]=1 -> same cycle m_rvalid[1]=1, m_rid=3, s_rready[1]=1; rr_ptr[1]=2 after edge; m_rvalid[0]=0.
- Round-robin fairness: S0, S1, S2 each present a 1-beat response to m0 continuously, m_rready[0]=1 -> grant order S0, S1, S2, S0 on 4 consecutive cycles.
- Burst lock: S2 sends a 4-beat burst to m0 while S0 requests m0 from beat 2; m_rready toggles 1,0,1,1,1 -> all 4 S2 beats delivered contiguously, S0 granted only the cycle after S2's rlast handshake.
- Concurrency: S0 sends a 4-beat burst to m0 and S1 a 4-beat burst to m1 simultaneously -> both complete in 4 cycles, no stalls.
- Bad index: S1 rid=0x52 with NUM_M=2 -> s_rready[1]=1, drop_err pulses 1 cycle, no m_rvalid asserted.
- Reset mid-burst: rst asserted after beat 2 of 4 -> all outputs 0 asynchronously; after release, rr_ptr=0 and a new S1 request is granted immediately (with AXI_RDX_PIPE_EN, it appears 1 cycle later).
